// File: rtl/hack_pkg.sv
// Shared Hack screen constants and the screen reader FSM state type.
package hack_pkg;

  localparam logic [14:0] SCREEN_BASE   = 15'h4000;
  localparam int          SCREEN_WORDS  = 8192;
  localparam int          SCREEN_W      = 512;
  localparam int          SCREEN_H      = 256;
  localparam int          SCREEN_ADDR_W = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/screen_reader_if.sv
// Screen RAM read port plus the pixel stream towards the video stage.
interface screen_reader_if #(
  parameter int ADDR_W = hack_pkg::SCREEN_ADDR_W
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_data;
  logic              pix_sol;
  logic              pix_sof;

  modport master (
    output mem_rd, mem_addr, pix_valid, pix_data, pix_sol, pix_sof,
    input  mem_data, pix_ready
  );

  modport slave (
    input  mem_rd, mem_addr, pix_valid, pix_data, pix_sol, pix_sof,
    output mem_data, pix_ready
  );
endinterface

// File: rtl/word_serializer.sv
// Two-word pixel buffer (shift + hold) that turns 16-bit screen words into
// a one-pixel-per-beat stream, LSB first.
module word_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        ret_valid_i,
  input  logic [15:0] ret_data_i,
  input  logic        pix_ready_i,
  output logic        pix_valid_o,
  output logic        pix_data_o,
  output logic        word_start_o,
  output logic        word_done_o,
  output logic        hold_full_o,
  output logic        hold_move_o
);

  logic [15:0] shift_q, shift_d, hold_q, hold_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic        shift_full_q, shift_full_d, hold_full_q, hold_full_d;
  logic [15:0] cur_word;
  logic        xfer, last;

  // With shift empty a returning word is presented straight from the RAM bus,
  // which removes one cycle of startup latency.
  assign cur_word     = shift_full_q ? shift_q : ret_data_i;
  assign pix_valid_o  = shift_full_q | ret_valid_i;
  assign pix_data_o   = pix_valid_o & cur_word[0];
  assign xfer         = pix_valid_o & pix_ready_i;
  assign last         = xfer & (bitcnt_q == 4'd15);
  assign word_start_o = (bitcnt_q == 4'd0);
  assign word_done_o  = last;
  assign hold_full_o  = hold_full_q;
  assign hold_move_o  = last & hold_full_q;

  always_comb begin
    shift_d      = shift_q;
    bitcnt_d     = bitcnt_q;
    shift_full_d = shift_full_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    if (!shift_full_q) begin
      if (ret_valid_i) begin
        shift_full_d = 1'b1;
        shift_d      = xfer ? (ret_data_i >> 1) : ret_data_i;
        bitcnt_d     = xfer ? 4'd1 : 4'd0;
      end
    end else if (last) begin
      bitcnt_d = '0;
      if (hold_full_q) begin
        shift_d     = hold_q;
        hold_d      = ret_data_i;
        hold_full_d = ret_valid_i;
      end else if (ret_valid_i) begin
        shift_d = ret_data_i;
      end else begin
        shift_full_d = 1'b0;
      end
    end else begin
      if (xfer) begin
        shift_d  = shift_q >> 1;
        bitcnt_d = bitcnt_q + 4'd1;
      end
      if (ret_valid_i) begin
        hold_d      = ret_data_i;
        hold_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q      <= '0;
      bitcnt_q     <= '0;
      shift_full_q <= 1'b0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
      shift_full_q <= shift_full_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
    end
  end

endmodule

// File: rtl/screen_reader.sv
// Raster-order reader of the Hack screen RAM: frame FSM, read addressing,
// line/column tracking and start-of-line/frame markers.
module screen_reader
  import hack_pkg::*;
#(
  parameter int WORDS_PER_LINE = 32,
  parameter int LINES          = 256,
  parameter int ADDR_W         = SCREEN_ADDR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             frame_done,
  screen_reader_if.master  bus
);

  localparam int COL_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int LINE_W = 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_LINE * LINES - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WORDS_PER_LINE - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] word_addr_q;
  logic              rd_pending_q;
  logic [COL_W-1:0]  col_q;
  logic [LINE_W-1:0] line_q;
  logic              frame_done_q;

  logic issue, word_start, word_done, hold_full, hold_move, end_of_frame;

  word_serializer u_ser (
    .clk          (clk),
    .reset        (reset),
    .ret_valid_i  (rd_pending_q),
    .ret_data_i   (bus.mem_data),
    .pix_ready_i  (bus.pix_ready),
    .pix_valid_o  (bus.pix_valid),
    .pix_data_o   (bus.pix_data),
    .word_start_o (word_start),
    .word_done_o  (word_done),
    .hold_full_o  (hold_full),
    .hold_move_o  (hold_move)
  );

  assign issue        = (state_q == ST_RUN) && !rd_pending_q && (!hold_full || hold_move);
  assign end_of_frame = word_done && (col_q == COL_LAST) && (line_q == LINE_LAST);

  assign bus.mem_rd   = issue;
  assign bus.mem_addr = word_addr_q;
  assign bus.pix_sol  = bus.pix_valid && word_start && (col_q == '0);
  assign bus.pix_sof  = bus.pix_sol && (line_q == '0);
  assign frame_done   = frame_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      word_addr_q  <= '0;
      rd_pending_q <= 1'b0;
      col_q        <= '0;
      line_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      rd_pending_q <= issue;
      if (issue) begin
        word_addr_q <= (word_addr_q == LAST_ADDR) ? '0 : word_addr_q + 1'b1;
      end
      // Counters track the word currently being presented, not the one being read.
      if (word_done) begin
        if (col_q == COL_LAST) begin
          col_q  <= '0;
          line_q <= (line_q == LINE_LAST) ? '0 : line_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      unique case (state_q)
        ST_IDLE:  if (enable) state_q <= ST_RUN;
        ST_RUN:   if (issue && (word_addr_q == LAST_ADDR)) state_q <= ST_DRAIN;
        ST_DRAIN: if (end_of_frame) begin
          state_q      <= ST_IDLE;
          frame_done_q <= 1'b1;
        end
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_reader.sv
// Directed bench for screen_reader on a reduced 4x4-word frame (256 pixels).
module tb_screen_reader;

  localparam int WPL  = 4;
  localparam int NL   = 4;
  localparam int NW   = WPL * NL;
  localparam int NPIX = NW * 16;
  localparam int PPL  = WPL * 16;
  localparam int NVEC = 14;

  typedef struct {
    logic d;
    logic sol;
    logic sof;
    int   cyc;
  } beat_t;

  typedef struct {
    int   idx;
    logic d;
    logic sol;
    logic sof;
  } vec_t;

  logic clk = 1'b0;
  logic reset, enable, frame_done;
  logic rnd_ready = 1'b0;

  logic [15:0] mem [NW];
  beat_t beats [$];
  int    rd_q  [$];
  vec_t  vt    [NVEC];

  int checks = 0, passes = 0;
  int cyc = 0, fd_cnt = 0, stall_seen = 0, stall_bad = 0;
  logic stall_prev = 1'b0, pd_prev = 1'b0, sol_prev = 1'b0, sof_prev = 1'b0;

  screen_reader_if #(.ADDR_W(13)) bus ();

  screen_reader #(.WORDS_PER_LINE(WPL), .LINES(NL), .ADDR_W(13)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .frame_done (frame_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data valid in the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr[3:0]];
  end

  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (bus.mem_rd) rd_q.push_back(int'(bus.mem_addr));
    if (frame_done) fd_cnt++;
    if (stall_prev) begin
      stall_seen++;
      if (!bus.pix_valid || bus.pix_data != pd_prev || bus.pix_sol != sol_prev ||
          bus.pix_sof != sof_prev) stall_bad++;
    end
    stall_prev = bus.pix_valid && !bus.pix_ready;
    pd_prev    = bus.pix_data;
    sol_prev   = bus.pix_sol;
    sof_prev   = bus.pix_sof;
    if (bus.pix_valid && bus.pix_ready)
      beats.push_back('{d: bus.pix_data, sol: bus.pix_sol, sof: bus.pix_sof, cyc: cyc});
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(input string tag, input int limit);
    int start = fd_cnt;
    int c = 0;
    while (fd_cnt == start && c < limit) begin
      @(posedge clk);
      c++;
    end
    check({tag, " frame_done"}, (fd_cnt != start) ? 1 : 0, 1);
    tick();
  endtask

  task automatic clear_logs();
    beats.delete();
    rd_q.delete();
    stall_seen = 0;
    stall_bad  = 0;
  endtask

  task automatic verify_frame(input string tag, input int off);
    int mism = 0, nsol = 0, nsof = 0;
    beat_t b;
    if (beats.size() < off + NPIX) begin
      mism = NPIX;
    end else begin
      for (int i = 0; i < NPIX; i++) begin
        b = beats[off + i];
        if (b.d !== mem[i / 16][i % 16] || b.sol !== ((i % PPL) == 0) || b.sof !== (i == 0))
          mism++;
        nsol += int'(b.sol);
        nsof += int'(b.sof);
      end
      for (int k = 0; k < NVEC; k++) begin
        b = beats[off + vt[k].idx];
        check($sformatf("%s vec_px%0d {d,sol,sof}", tag, vt[k].idx),
              int'({b.d, b.sol, b.sof}), int'({vt[k].d, vt[k].sol, vt[k].sof}));
      end
    end
    check({tag, " pixel_stream_mismatches"}, mism, 0);
    check({tag, " sol_count"}, nsol, NL);
    check({tag, " sof_count"}, nsof, 1);
  endtask

  task automatic verify_reads(input string tag, input int off);
    int mism = 0;
    if (rd_q.size() < off + NW) mism = NW;
    else for (int k = 0; k < NW; k++) if (rd_q[off + k] != k) mism++;
    check({tag, " read_addr_mismatches"}, mism, 0);
  endtask

  initial begin
    int c;
    // Hand-computed spot pixels: word0=0001, word1=8000, word n>=2 holds n.
    vt[0]  = '{0,   1'b1, 1'b1, 1'b1};
    vt[1]  = '{1,   1'b0, 1'b0, 1'b0};
    vt[2]  = '{15,  1'b0, 1'b0, 1'b0};
    vt[3]  = '{16,  1'b0, 1'b0, 1'b0};
    vt[4]  = '{31,  1'b1, 1'b0, 1'b0};
    vt[5]  = '{32,  1'b0, 1'b0, 1'b0};
    vt[6]  = '{33,  1'b1, 1'b0, 1'b0};
    vt[7]  = '{64,  1'b0, 1'b1, 1'b0};
    vt[8]  = '{66,  1'b1, 1'b0, 1'b0};
    vt[9]  = '{131, 1'b1, 1'b0, 1'b0};
    vt[10] = '{192, 1'b0, 1'b1, 1'b0};
    vt[11] = '{194, 1'b1, 1'b0, 1'b0};
    vt[12] = '{240, 1'b1, 1'b0, 1'b0};
    vt[13] = '{255, 1'b0, 1'b0, 1'b0};
    for (int a = 0; a < NW; a++) mem[a] = 16'(a);
    mem[0] = 16'h0001;
    mem[1] = 16'h8000;

    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) tick();
    check("reset_outputs", int'({bus.mem_rd, bus.mem_addr, bus.pix_valid, bus.pix_data,
                                 bus.pix_sol, bus.pix_sof, frame_done}), 0);
    reset = 1'b0;
    tick();

    // Startup latency and a gap-free frame with ready held high.
    clear_logs();
    enable = 1'b1;
    tick();
    check("start mem_rd", int'(bus.mem_rd), 1);
    check("start mem_addr", int'(bus.mem_addr), 0);
    check("start valid_before_data", int'(bus.pix_valid), 0);
    enable = 1'b0;
    tick();
    check("first_pixel {valid,sof,sol,data}",
          int'({bus.pix_valid, bus.pix_sof, bus.pix_sol, bus.pix_data}), 15);
    wait_frame("f1", 4 * NPIX);
    check("f1 beats", beats.size(), NPIX);
    if (beats.size() == NPIX)
      check("f1 gapless_span", beats[NPIX - 1].cyc - beats[0].cyc, NPIX - 1);
    verify_frame("f1", 0);
    verify_reads("f1", 0);
    check("f1 frame_done_pulses", fd_cnt, 1);
    repeat (6) tick();
    check("f1 idle_no_reads", rd_q.size(), NW);

    // Random backpressure: same stream, stable outputs while stalled.
    clear_logs();
    rnd_ready = 1'b1;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_frame("rnd", 8 * NPIX);
    rnd_ready = 1'b0;
    check("rnd beats", beats.size(), NPIX);
    verify_frame("rnd", 0);
    verify_reads("rnd", 0);
    check("rnd reads_total", rd_q.size(), NW);
    check("rnd stalls_seen", (stall_seen > 0) ? 1 : 0, 1);
    check("rnd stall_instability", stall_bad, 0);

    // Reset in mid-frame, then a clean restart.
    clear_logs();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    c = 0;
    while (beats.size() < 50 && c < 500) begin
      tick();
      c++;
    end
    check("rst reached_pixel_50", (beats.size() >= 50) ? 1 : 0, 1);
    reset = 1'b1;
    tick();
    check("rst midframe_outputs", int'({bus.mem_rd, bus.mem_addr, bus.pix_valid, bus.pix_data,
                                        bus.pix_sol, bus.pix_sof, frame_done}), 0);
    reset = 1'b0;
    tick();
    check("rst stays_quiet", int'({bus.mem_rd, bus.pix_valid}), 0);
    clear_logs();
    enable = 1'b1;
    tick();
    check("rst restart {rd,addr}", int'({bus.mem_rd, bus.mem_addr}), 1 << 13);
    enable = 1'b0;
    wait_frame("rst", 4 * NPIX);
    verify_frame("rst", 0);
    verify_reads("rst", 0);

    // Back-to-back frames with enable held, dropped midway through frame two.
    clear_logs();
    enable = 1'b1;
    wait_frame("b2b1", 4 * NPIX);
    c = 0;
    while (beats.size() < NPIX + 20 && c < 500) begin
      tick();
      c++;
    end
    enable = 1'b0;
    wait_frame("b2b2", 4 * NPIX);
    check("b2b beats", beats.size(), 2 * NPIX);
    if (beats.size() == 2 * NPIX)
      check("b2b valid_gap", beats[NPIX].cyc - beats[NPIX - 1].cyc - 1, 2);
    verify_frame("b2b2", NPIX);
    verify_reads("b2b1", 0);
    verify_reads("b2b2", NW);
    repeat (6) tick();
    check("b2b no_third_frame", rd_q.size(), 2 * NW);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
